// File: rtl/pipe_pkg.sv
// Shared types for the pipeline write arbiter: state/grant encodings and
// the burst beat-counter width helper.
package pipe_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_GNT0 = 2'b01,
        ARB_GNT1 = 2'b10
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_REQ0 = 2'b01;
    localparam logic [1:0] GRANT_REQ1 = 2'b10;

    // Bits needed to count 0..burst_len inclusive.
    function automatic int beat_cnt_width(input int burst_len);
        return $clog2(burst_len + 1);
    endfunction

endpackage

// File: rtl/pipe_wr_rr_arbiter_sat_counter.sv
// Saturating up-counter: holds at all-ones once reached, cleared only by reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_wr_rr_arbiter.sv
// Two-requester round-robin write arbiter with burst grants in front of a
// single-slot pipeline stage. Optional beat statistics under ARB_STATS_EN.
module pipe_wr_rr_arbiter
    import pipe_pkg::*;
#(
    parameter int DSIZE     = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [DSIZE-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [DSIZE-1:0] req1_data,
    output logic             req1_ready,
    input  logic             stage_sum_empty,
    output logic             wr_en0,
    output logic [DSIZE-1:0] indata0,
    output logic             wr_en1,
    output logic [DSIZE-1:0] indata1,
    output logic [1:0]       grant,
    output logic [CNT_W-1:0] beats0_cnt,
    output logic [CNT_W-1:0] beats1_cnt
);

    localparam int             BW        = beat_cnt_width(BURST_LEN);
    localparam logic [BW-1:0]  BURST_MAX = BW'(BURST_LEN);

    // Handshake: a beat moves on a requester port only in a cycle where both
    // its valid and its ready are high; ready never depends on valid.
    arb_state_t    state, state_next;
    logic          last_served, last_served_next;
    logic [BW-1:0] beat_cnt, beat_cnt_next;
    logic [BW-1:0] cnt_inc;
    logic          beat, own_valid, oth_valid;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB_IDLE;
            last_served <= 1'b1;
            beat_cnt    <= '0;
        end else begin
            state       <= state_next;
            last_served <= last_served_next;
            beat_cnt    <= beat_cnt_next;
        end
    end

    assign beat      = wr_en0 | wr_en1;
    assign cnt_inc   = beat_cnt + BW'(1);
    assign own_valid = (state == ARB_GNT0) ? req0_valid : req1_valid;
    assign oth_valid = (state == ARB_GNT0) ? req1_valid : req0_valid;

    always_comb begin
        state_next       = state;
        last_served_next = last_served;
        beat_cnt_next    = beat_cnt;
        unique case (state)
            ARB_IDLE: begin
                if (req0_valid && (!req1_valid || last_served)) begin
                    state_next = ARB_GNT0;
                end else if (req1_valid) begin
                    state_next = ARB_GNT1;
                end
            end
            ARB_GNT0, ARB_GNT1: begin
                if (beat) begin
                    beat_cnt_next = cnt_inc;
                end
                // Exit on the burst's final beat or when the owner goes quiet.
                if (!own_valid || (beat && (cnt_inc == BURST_MAX))) begin
                    beat_cnt_next    = '0;
                    last_served_next = (state == ARB_GNT1);
                    if (oth_valid) begin
                        state_next = (state == ARB_GNT0) ? ARB_GNT1 : ARB_GNT0;
                    end else if (own_valid) begin
                        state_next = state;
                    end else begin
                        state_next = ARB_IDLE;
                    end
                end
            end
            default: begin
                state_next    = ARB_IDLE;
                beat_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        wr_en0     = 1'b0;
        wr_en1     = 1'b0;
        indata0    = '0;
        indata1    = '0;
        grant      = state;
        if (state == ARB_GNT0) begin
            req0_ready = stage_sum_empty;
            wr_en0     = req0_valid & stage_sum_empty;
        end else if (state == ARB_GNT1) begin
            req1_ready = stage_sum_empty;
            wr_en1     = req1_valid & stage_sum_empty;
        end
        // Both stage ports carry the beat so the stage's port mux is moot.
        if (wr_en0) begin
            indata0 = req0_data;
            indata1 = req0_data;
        end else if (wr_en1) begin
            indata0 = req1_data;
            indata1 = req1_data;
        end
    end

`ifdef ARB_STATS_EN
    sat_counter #(.W(CNT_W)) u_beats0 (
        .clock (clock),
        .rst_n (rst_n),
        .inc   (wr_en0),
        .count (beats0_cnt)
    );

    sat_counter #(.W(CNT_W)) u_beats1 (
        .clock (clock),
        .rst_n (rst_n),
        .inc   (wr_en1),
        .count (beats1_cnt)
    );
`else
    assign beats0_cnt = '0;
    assign beats1_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_wr_rr_arbiter.sv
// Directed bench for pipe_wr_rr_arbiter (BURST_LEN=4, CNT_W=4); the stats
// checks follow ARB_STATS_EN.
module tb_pipe_wr_rr_arbiter;

    logic       clock;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       stage_sum_empty;
    logic       wr_en0, wr_en1;
    logic [7:0] indata0, indata1;
    logic [1:0] grant;
    logic [3:0] beats0_cnt, beats1_cnt;

    int checks   = 0;
    int failures = 0;

    pipe_wr_rr_arbiter #(.DSIZE(8), .BURST_LEN(4), .CNT_W(4)) dut (
        .clock           (clock),
        .rst_n           (rst_n),
        .req0_valid      (req0_valid),
        .req0_data       (req0_data),
        .req0_ready      (req0_ready),
        .req1_valid      (req1_valid),
        .req1_data       (req1_data),
        .req1_ready      (req1_ready),
        .stage_sum_empty (stage_sum_empty),
        .wr_en0          (wr_en0),
        .indata0         (indata0),
        .wr_en1          (wr_en1),
        .indata1         (indata1),
        .grant           (grant),
        .beats0_cnt      (beats0_cnt),
        .beats1_cnt      (beats1_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] g, input logic w0,
                              input logic w1, input logic [7:0] d);
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".wr_en0"}, 32'(wr_en0), 32'(w0));
        check({tag, ".wr_en1"}, 32'(wr_en1), 32'(w1));
        check({tag, ".indata0"}, 32'(indata0), 32'(d));
        check({tag, ".indata1"}, 32'(indata1), 32'(d));
    endtask

    initial begin
        logic       owner1;
        logic [7:0] d;

        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data = 8'h11;
        req1_data = 8'h22;
        stage_sum_empty = 1'b1;
        repeat (2) step();
        #2;
        expect_out("reset", 2'b00, 1'b0, 1'b0, 8'h00);
        check("reset.req0_ready", 32'(req0_ready), 32'd0);
        check("reset.req1_ready", 32'(req1_ready), 32'd0);
        check("reset.beats0", 32'(beats0_cnt), 32'd0);
        check("reset.beats1", 32'(beats1_cnt), 32'd0);

        // Release with both valid: 4 beats req0, 4 req1, 4 req0.
        step();
        rst_n = 1'b1;
        #2;
        expect_out("idle0", 2'b00, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 12; k++) begin
            step();
            req0_data = 8'(8'h10 + k);
            req1_data = 8'(8'h80 + k);
            #2;
            owner1 = ((k / 4) % 2) == 1;
            d = owner1 ? req1_data : req0_data;
            expect_out($sformatf("rr%0d", k), owner1 ? 2'b10 : 2'b01, !owner1, owner1, d);
        end

        // Owner drops valid mid-beat: no write, then idle.
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #2;
        expect_out("drop", 2'b01, 1'b0, 1'b0, 8'h00);
        step();
        #2;
        expect_out("idle1", 2'b00, 1'b0, 1'b0, 8'h00);

        // Only req1 valid.
        req1_valid = 1'b1;
        req1_data = 8'hA5;
        #2;
        expect_out("r1_wait", 2'b00, 1'b0, 1'b0, 8'h00);
        step();
        #2;
        expect_out("r1_only", 2'b10, 1'b0, 1'b1, 8'hA5);
        check("r1_only.req0_ready", 32'(req0_ready), 32'd0);
        check("r1_only.req1_ready", 32'(req1_ready), 32'd1);

        // Hand over to req0, then stall the stage for 3 cycles after one beat.
        req1_valid = 1'b0;
        req0_valid = 1'b1;
        req0_data = 8'h33;
        #2;
        expect_out("handover", 2'b10, 1'b0, 1'b0, 8'h00);
        step();
        #2;
        expect_out("st_beat1", 2'b01, 1'b1, 1'b0, 8'h33);
        for (int s = 0; s < 3; s++) begin
            step();
            stage_sum_empty = 1'b0;
            #2;
            expect_out($sformatf("stall%0d", s), 2'b01, 1'b0, 1'b0, 8'h00);
            check($sformatf("stall%0d.req0_ready", s), 32'(req0_ready), 32'd0);
        end
        step();
        stage_sum_empty = 1'b1;
        req1_valid = 1'b1;
        req1_data = 8'h44;
        #2;
        expect_out("st_beat2", 2'b01, 1'b1, 1'b0, 8'h33);
        step();
        #2;
        expect_out("st_beat3", 2'b01, 1'b1, 1'b0, 8'h33);
        step();
        #2;
        expect_out("st_beat4", 2'b01, 1'b1, 1'b0, 8'h33);
        step();
        #2;
        expect_out("st_switch", 2'b10, 1'b0, 1'b1, 8'h44);

        // req1 finishes its burst; req0 takes 2 beats then drops valid.
        for (int b = 0; b < 3; b++) begin
            step();
            #2;
            expect_out($sformatf("r1b%0d", b + 2), 2'b10, 1'b0, 1'b1, 8'h44);
        end
        step();
        req0_data = 8'h55;
        #2;
        expect_out("r0b1", 2'b01, 1'b1, 1'b0, 8'h55);
        step();
        #2;
        expect_out("r0b2", 2'b01, 1'b1, 1'b0, 8'h55);
        step();
        req0_valid = 1'b0;
        #2;
        expect_out("bubble", 2'b01, 1'b0, 1'b0, 8'h00);
        step();
        req0_valid = 1'b1;
        #2;
        expect_out("after_bubble", 2'b10, 1'b0, 1'b1, 8'h44);

        // Asynchronous reset mid-burst in GNT1.
        step();
        #2;
        expect_out("pre_rst", 2'b10, 1'b0, 1'b1, 8'h44);
        rst_n = 1'b0;
        #1;
        expect_out("mid_rst", 2'b00, 1'b0, 1'b0, 8'h00);
        step();
        rst_n = 1'b1;
        #2;
        expect_out("post_rst_idle", 2'b00, 1'b0, 1'b0, 8'h00);
        step();
        #2;
        expect_out("post_rst_tie", 2'b01, 1'b1, 1'b0, 8'h55);

        // req0 streams alone: re-granted with no bubbles, 20 beats total.
        req1_valid = 1'b0;
        for (int b = 1; b < 20; b++) begin
            step();
            #2;
            check($sformatf("stream%0d.grant", b), 32'(grant), 32'(2'b01));
            check($sformatf("stream%0d.wr_en0", b), 32'(wr_en0), 32'd1);
        end
        step();
        req0_valid = 1'b0;
        #2;
`ifdef ARB_STATS_EN
        check("stats.beats0", 32'(beats0_cnt), 32'hF);
`else
        check("stats.beats0", 32'(beats0_cnt), 32'h0);
`endif
        check("stats.beats1", 32'(beats1_cnt), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_wr_rr_arbiter.md
Name: pipe_wr_rr_arbiter

Overview:
- Two-requester round-robin write arbiter sitting in front of a two-write-port pipeline register stage.
- Shares the stage's single storage slot between two valid/ready producers.
- Issues at most one stage write per cycle, and only when the stage can accept it (stage sum_empty high).
- Supports burst grants of up to BURST_LEN beats so a requester keeps ownership across back-to-back beats.

Parameters:
- DSIZE, 8, data width of requesters and stage ports.
- BURST_LEN, 4, max consecutive beats per grant; legal range 1..255.
- CNT_W, 16, width of statistics counters (used only with ARB_STATS_EN).

Ports:
- clock  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req0_valid  in  1  requester 0 has data.
- req0_data  in  DSIZE  requester 0 data.
- req0_ready  out  1  requester 0 beat accepted this cycle.
- req1_valid  in  1  requester 1 has data.
- req1_data  in  DSIZE  requester 1 data.
- req1_ready  out  1  requester 1 beat accepted this cycle.
- stage_sum_empty  in  1  stage can take a write this cycle (stage empty or its downstream empty).
- wr_en0  out  1  stage write enable, port 0 (requester 0 beat).
- indata0  out  DSIZE  stage data, port 0.
- wr_en1  out  1  stage write enable, port 1 (requester 1 beat).
- indata1  out  DSIZE  stage data, port 1.
- grant  out  2  one-hot registered grant: 01 = req0, 10 = req1, 00 = idle.
- beats0_cnt  out  CNT_W  accepted-beat count for requester 0 (ARB_STATS_EN only).
- beats1_cnt  out  CNT_W  accepted-beat count for requester 1 (ARB_STATS_EN only).

Behaviour:
Reset values:
- State IDLE, grant 00, last_served = 1 (so req0 wins the first tie), beat_cnt 0.
- All ready and wr_en outputs 0; indata0/indata1 0; stats counters 0.

State machine and grant:
- States are IDLE, GNT0 and GNT1; grant is the registered state encoding.
- IDLE -> GNT0 if req0_valid & (!req1_valid | last_served==1).
- IDLE -> GNT1 if req1_valid & (!req0_valid | last_served==0).
- IDLE stays IDLE otherwise.

Beats (combinational from registered state):
- In GNTx: reqx_ready = stage_sum_empty; wr_enx = reqx_valid & stage_sum_empty.
- The other requester's ready and wr_en are 0. In IDLE all are 0.
- wr_en0 and wr_en1 are never both 1.
- indata0 and indata1 both carry the granted requester's data. They carry 0 when no beat is issued, so the stage's internal port mux is irrelevant.

Burst accounting:
- beat_cnt increments on each beat and clears on any grant change.
- GNTx exits after a beat that brings beat_cnt to BURST_LEN, or when reqx_valid is low.
- Exit target:
  - the other state if the other requester is valid;
  - else GNTx again (beat_cnt cleared) if reqx_valid is still high;
  - else IDLE.
- last_served updates to x on exit from GNTx.
- A stalled grant (valid high, stage_sum_empty low) holds state and beat_cnt; there is no timeout.

Latency and throughput:
- Request in IDLE: first beat one cycle after valid rises.
- A grant switch costs zero bubbles when the exit is decided on a beat cycle.
- It costs one bubble when the exit is caused by valid low.
- Sustained throughput is 1 beat/cycle while stage_sum_empty is high.

Boundary conditions:
- Both requesters valid continuously, BURST_LEN=4: the pattern is 4 beats req0, 4 beats req1, repeating.
- BURST_LEN=1: strict alternation.
- Requester drops valid mid-burst: the beat is lost to no one, and no write is issued that cycle.
- Reset mid-burst: immediate return to reset values; no wr_en is asserted during reset.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined: beats0_cnt and beats1_cnt increment on each accepted beat of their requester. They saturate at all-ones and are cleared only by reset.
- Undefined: no counter logic; both stats outputs are tied to 0.

Decomposition:
- Shared package pipe_pkg holds:
  - the state encoding constants ARB_IDLE=2'b00, ARB_GNT0=2'b01, ARB_GNT1=2'b10;
  - the grant one-hot constants;
  - a beat-counter width function (clog2(BURST_LEN+1)).
- One natural sub-module, sat_counter (width param, inc, saturating), instantiated twice under ARB_STATS_EN.

Test Plan:
- Reset release with req0_valid=1 and req1_valid=1 held, stage_sum_empty=1, BURST_LEN=4 -> cycle 1 grant=01; beats req0 on cycles 1-4, req1 on 5-8, req0 on 9-12; wr_en one-hot on every beat.
- Only req1_valid=1, data 8'hA5 -> grant=10 one cycle later; wr_en1=1; indata0=indata1=8'hA5; req0_ready=0.
- Granted req0 with stage_sum_empty forced 0 for 3 cycles -> no wr_en, req0_ready=0, state and beat_cnt held; resumes at the same beat count when released.
- req0 drops valid after 2 beats while req1 is valid -> one idle cycle, then grant=10; last_served=0.
- rst_n asserted low mid-burst in GNT1 -> same-cycle wr_en1=0 and grant=00; after release with both valid, req0 granted first.
- ARB_STATS_EN defined, CNT_W=4, req0 streaming 20 beats -> beats0_cnt saturates at 4'hF; beats1_cnt=0.
